// File: rtl/fp_arith_prestage.sv
// Two-stage front-end for the FP multiply/divide core: unpack, classify, result exponent and exception code.
// Define FP_ARITH_PRESTAGE_SUBNORM_EN to keep subnormals (exponent 1, hidden bit 0) instead of flushing them to zero.
module fp_arith_prestage #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int BIAS  = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_in_valid,
  output logic                   io_in_ready,
  input  logic                   io_op,
  input  logic [EXP_W+MAN_W:0]   io_fpin1,
  input  logic [EXP_W+MAN_W:0]   io_fpin2,
  output logic                   io_out_valid,
  input  logic                   io_out_ready,
  output logic [EXP_W-1:0]       io_exp_out,
  output logic [MAN_W:0]         io_mout1,
  output logic [MAN_W:0]         io_mout2,
  output logic                   io_sign,
  output logic [2:0]             io_except_code
);

  localparam int W  = EXP_W + MAN_W + 1;
  localparam int EW = EXP_W + 2;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [EW-1:0]    BIAS_E   = EW'(BIAS);
  localparam logic signed [EW-1:0]    EMAX_E   = EW'((1 << EXP_W) - 1);

  localparam logic [2:0] CODE_NONE = 3'd0;
  localparam logic [2:0] CODE_OVF  = 3'd1;
  localparam logic [2:0] CODE_UNF  = 3'd2;
  localparam logic [2:0] CODE_DZ   = 3'd3;
  localparam logic [2:0] CODE_INF  = 3'd4;
  localparam logic [2:0] CODE_NAN  = 3'd5;
  localparam logic [2:0] CODE_ZERO = 3'd6;

  typedef struct packed {
    logic             op;
    logic             sa;
    logic             sb;
    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [MAN_W:0]   ma;
    logic [MAN_W:0]   mb;
    logic             za;
    logic             zb;
    logic             ia;
    logic             ib;
    logic             na;
    logic             nb;
  } s1_t;

  typedef struct packed {
    logic [EXP_W-1:0] exp_o;
    logic [MAN_W:0]   m1;
    logic [MAN_W:0]   m2;
    logic             sign;
    logic [2:0]       code;
  } s2_t;

  // Handshake: a stage moves when its slot is empty or the stage after it moves;
  // a transfer happens only when valid and ready are both high in the same cycle.
  logic v1_q, v1_d, v2_q, v2_d;
  logic adv1, adv2;
  s1_t  s1_q, s1_d, s1_new;
  s2_t  s2_q, s2_d, s2_new;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_man, b_man;
  logic             a_exp_zero, b_exp_zero, a_exp_ones, b_exp_ones;
  logic             a_man_zero, b_man_zero;

  logic signed [EW-1:0] ea_s, eb_s, e_wide;
  logic is_div, sp_nan, sp_dz, sp_inf, sp_zero;

  always_comb begin
    adv2        = !v2_q || io_out_ready;
    adv1        = !v1_q || adv2;
    io_in_ready = adv1;
  end

  // Stage 1: unpack and classify
  always_comb begin
    a_exp      = io_fpin1[W-2:MAN_W];
    b_exp      = io_fpin2[W-2:MAN_W];
    a_man      = io_fpin1[MAN_W-1:0];
    b_man      = io_fpin2[MAN_W-1:0];
    a_exp_zero = (a_exp == '0);
    b_exp_zero = (b_exp == '0);
    a_exp_ones = (a_exp == EXP_ONES);
    b_exp_ones = (b_exp == EXP_ONES);
    a_man_zero = (a_man == '0);
    b_man_zero = (b_man == '0);

    s1_new    = '0;
    s1_new.op = io_op;
    s1_new.sa = io_fpin1[W-1];
    s1_new.sb = io_fpin2[W-1];
    s1_new.ma = {!a_exp_zero && !a_exp_ones, a_man};
    s1_new.mb = {!b_exp_zero && !b_exp_ones, b_man};
    s1_new.ia = a_exp_ones && a_man_zero;
    s1_new.ib = b_exp_ones && b_man_zero;
    s1_new.na = a_exp_ones && !a_man_zero;
    s1_new.nb = b_exp_ones && !b_man_zero;
`ifdef FP_ARITH_PRESTAGE_SUBNORM_EN
    s1_new.za = a_exp_zero && a_man_zero;
    s1_new.zb = b_exp_zero && b_man_zero;
    s1_new.ea = a_exp_zero ? EXP_W'(1) : a_exp;
    s1_new.eb = b_exp_zero ? EXP_W'(1) : b_exp;
`else
    s1_new.za = a_exp_zero;
    s1_new.zb = b_exp_zero;
    s1_new.ea = a_exp;
    s1_new.eb = b_exp;
`endif

    v1_d = adv1 ? io_in_valid : v1_q;
    s1_d = s1_q;
    if (adv1 && io_in_valid) s1_d = s1_new;
  end

  // Stage 2: exponent arithmetic and prioritised exception code
  always_comb begin
    is_div = !s1_q.op;
    ea_s   = $signed({2'b00, s1_q.ea});
    eb_s   = $signed({2'b00, s1_q.eb});
    e_wide = s1_q.op ? (ea_s + eb_s - BIAS_E) : (ea_s - eb_s + BIAS_E);

    sp_nan  = s1_q.na || s1_q.nb
           || (is_div && s1_q.za && s1_q.zb)
           || (is_div && s1_q.ia && s1_q.ib)
           || (s1_q.op && ((s1_q.za && s1_q.ib) || (s1_q.ia && s1_q.zb)));
    sp_dz   = is_div && s1_q.zb && !s1_q.za && !s1_q.ia && !s1_q.na;
    sp_inf  = s1_q.ia || (s1_q.op && s1_q.ib);
    sp_zero = s1_q.za || (is_div && s1_q.ib) || (s1_q.op && s1_q.zb);

    s2_new      = '0;
    s2_new.m1   = s1_q.ma;
    s2_new.m2   = s1_q.mb;
    s2_new.sign = s1_q.sa ^ s1_q.sb;
    if (sp_nan) begin
      s2_new.code  = CODE_NAN;
      s2_new.exp_o = EXP_ONES;
    end else if (sp_dz) begin
      s2_new.code  = CODE_DZ;
      s2_new.exp_o = EXP_ONES;
    end else if (sp_inf) begin
      s2_new.code  = CODE_INF;
      s2_new.exp_o = EXP_ONES;
    end else if (sp_zero) begin
      s2_new.code  = CODE_ZERO;
      s2_new.exp_o = '0;
    end else if (e_wide >= EMAX_E) begin
      s2_new.code  = CODE_OVF;
      s2_new.exp_o = EXP_ONES;
    end else if (e_wide[EW-1] || (e_wide == '0)) begin
      s2_new.code  = CODE_UNF;
      s2_new.exp_o = '0;
    end else begin
      s2_new.code  = CODE_NONE;
      s2_new.exp_o = e_wide[EXP_W-1:0];
    end

    v2_d = adv2 ? v1_q : v2_q;
    s2_d = s2_q;
    if (adv2 && v1_q) s2_d = s2_new;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_comb begin
    io_out_valid   = v2_q;
    io_exp_out     = s2_q.exp_o;
    io_mout1       = s2_q.m1;
    io_mout2       = s2_q.m2;
    io_sign        = s2_q.sign;
    io_except_code = s2_q.code;
  end

endmodule

// File: tb/tb_fp_arith_prestage.sv
// Self-checking bench for fp_arith_prestage: directed table, backpressure, reset flush and random streaming
// against an arithmetic reference model.
module tb_fp_arith_prestage;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;
  localparam int W     = EXP_W + MAN_W + 1;
  localparam int OUT_W = EXP_W + 2 * (MAN_W + 1) + 1 + 3;

  logic             clock, reset;
  logic             io_in_valid, io_in_ready, io_op;
  logic [W-1:0]     io_fpin1, io_fpin2;
  logic             io_out_valid, io_out_ready;
  logic [EXP_W-1:0] io_exp_out;
  logic [MAN_W:0]   io_mout1, io_mout2;
  logic             io_sign;
  logic [2:0]       io_except_code;
  logic [OUT_W-1:0] dut_word;

  int checks = 0;
  int errors = 0;
  logic [OUT_W-1:0] exp_q[$];

  fp_arith_prestage #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_op(io_op), .io_fpin1(io_fpin1), .io_fpin2(io_fpin2),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_exp_out(io_exp_out), .io_mout1(io_mout1), .io_mout2(io_mout2),
    .io_sign(io_sign), .io_except_code(io_except_code)
  );

  assign dut_word = {io_exp_out, io_mout1, io_mout2, io_sign, io_except_code};

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: works on integer field values and the classification rules directly.
  function automatic logic [OUT_W-1:0] model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ea, eb, ma, mb, emax, xa, xb, e, code, eo;
    bit nan_a, nan_b, inf_a, inf_b, z_a, z_b, subn, hid_a, hid_b;
    logic [EXP_W-1:0] eo_v;
    logic [2:0] code_v;
    emax = (1 << EXP_W) - 1;
`ifdef FP_ARITH_PRESTAGE_SUBNORM_EN
    subn = 1;
`else
    subn = 0;
`endif
    ea = int'(a[W-2:MAN_W]);
    eb = int'(b[W-2:MAN_W]);
    ma = int'(a[MAN_W-1:0]);
    mb = int'(b[MAN_W-1:0]);
    nan_a = (ea == emax) && (ma != 0);
    nan_b = (eb == emax) && (mb != 0);
    inf_a = (ea == emax) && (ma == 0);
    inf_b = (eb == emax) && (mb == 0);
    z_a   = (ea == 0) && ((ma == 0) || !subn);
    z_b   = (eb == 0) && ((mb == 0) || !subn);
    hid_a = (ea != 0) && (ea != emax);
    hid_b = (eb != 0) && (eb != emax);
    xa = (ea == 0 && subn) ? 1 : ea;
    xb = (eb == 0 && subn) ? 1 : eb;
    e  = op ? (xa + xb - BIAS) : (xa - xb + BIAS);
    if (nan_a || nan_b || (!op && z_a && z_b) || (!op && inf_a && inf_b) ||
        (op && ((z_a && inf_b) || (inf_a && z_b)))) begin
      code = 5; eo = emax;
    end else if (!op && z_b && !z_a && !inf_a) begin
      code = 3; eo = emax;
    end else if (inf_a || (op && inf_b)) begin
      code = 4; eo = emax;
    end else if (z_a || (!op && inf_b) || (op && z_b)) begin
      code = 6; eo = 0;
    end else if (e >= emax) begin
      code = 1; eo = emax;
    end else if (e <= 0) begin
      code = 2; eo = 0;
    end else begin
      code = 0; eo = e;
    end
    eo_v   = eo[EXP_W-1:0];
    code_v = code[2:0];
    return {eo_v, hid_a, a[MAN_W-1:0], hid_b, b[MAN_W-1:0], a[W-1] ^ b[W-1], code_v};
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic             s;
    case ($urandom_range(0, 5))
      0:       e = '0;
      1:       e = '1;
      default: e = EXP_W'($urandom_range(1, (1 << EXP_W) - 2));
    endcase
    m = ($urandom_range(0, 2) == 0) ? '0 : MAN_W'($urandom);
    s = 1'($urandom_range(0, 1));
    return {s, e, m};
  endfunction

  task automatic test_reset();
    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", io_out_valid); end
    checks++;
    if (dut_word !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", dut_word); end
    checks++;
    if (io_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", io_in_ready); end
  endtask

  task automatic test_directed();
    logic          t_op[8]   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0]  t_a[8]    = '{16'h3C00, 16'h4000, 16'h7BFF, 16'h0400, 16'hBC00, 16'h0000, 16'h7C00, 16'h0001};
    logic [W-1:0]  t_b[8]    = '{16'h4000, 16'hC200, 16'h0400, 16'h7800, 16'h0000, 16'h0000, 16'h3C00, 16'h3C00};
`ifdef FP_ARITH_PRESTAGE_SUBNORM_EN
    logic [2:0]    t_code[8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0};
    int            t_exp[8]  = '{14, 17, 31, 0, 31, 31, 31, 1};
`else
    logic [2:0]    t_code[8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6};
    int            t_exp[8]  = '{14, 17, 31, 0, 31, 31, 31, 0};
`endif
    logic [OUT_W-1:0] want;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock);
      #1 io_op = t_op[i]; io_fpin1 = t_a[i]; io_fpin2 = t_b[i]; io_in_valid = 1'b1; io_out_ready = 1'b1;
      want = model(t_op[i], t_a[i], t_b[i]);
      @(negedge clock);
      checks++;
      if (io_in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, io_in_ready); end
      @(posedge clock);
      #1 io_in_valid = 1'b0;
      @(negedge clock);
      checks++;
      if (io_out_valid !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b want 0", i, io_out_valid); end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (io_out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: out_valid got %b want 1", i, io_out_valid); end
      checks++;
      if (dut_word !== want) begin errors++; $display("FAIL dir%0d_word: got %h want %h", i, dut_word, want); end
      checks++;
      if (io_except_code !== t_code[i] || int'(io_exp_out) != t_exp[i])
        begin errors++; $display("FAIL dir%0d_code_exp: got code %0d exp %0d want code %0d exp %0d",
                                 i, io_except_code, io_exp_out, t_code[i], t_exp[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] pa[4], pb[4];
    logic         pop[4];
    logic [OUT_W-1:0] held, want;
    bit stalled;
    int sent, got;
    sent = 0; got = 0; stalled = 0; held = '0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      pa[i] = rand_operand(); pb[i] = rand_operand(); pop[i] = 1'($urandom_range(0, 1));
    end
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(posedge clock);
      #1 io_out_ready = (cyc >= 8);
      if (sent < 4) begin
        io_in_valid = 1'b1; io_op = pop[sent]; io_fpin1 = pa[sent]; io_fpin2 = pb[sent];
      end else io_in_valid = 1'b0;
      @(negedge clock);
      if (cyc == 7) begin
        checks++;
        if (sent != 2) begin errors++; $display("FAIL bp_accepted: got %0d want 2", sent); end
        checks++;
        if (io_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", io_in_ready); end
      end
      if (stalled) begin
        checks++;
        if (dut_word !== held || io_out_valid !== 1'b1)
          begin errors++; $display("FAIL bp_stable: got %h want %h", dut_word, held); end
      end
      stalled = io_out_valid && !io_out_ready;
      held = dut_word;
      if (io_out_valid && io_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL bp_extra: got %h want none", dut_word); end
        else begin
          want = exp_q.pop_front();
          if (dut_word !== want) begin errors++; $display("FAIL bp_order%0d: got %h want %h", got, dut_word, want); end
        end
        got++;
      end
      if (io_in_valid && io_in_ready) begin
        exp_q.push_back(model(io_op, io_fpin1, io_fpin2));
        sent++;
      end
    end
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (got != 4 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d want 4", got); end
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL bp_duplicate: out_valid got %b want 0", io_out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [OUT_W-1:0] want;
    io_out_ready = 1'b0;
    @(posedge clock);
    #1 io_in_valid = 1'b1; io_op = 1'b1; io_fpin1 = 16'h4000; io_fpin2 = 16'h4000;
    @(posedge clock);
    #1 io_fpin1 = 16'h3C00;
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0)
      begin errors++; $display("FAIL rst_full: got valid %b ready %b want 1 0", io_out_valid, io_in_ready); end
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0; io_out_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0 || dut_word !== '0 || io_in_ready !== 1'b1)
      begin errors++; $display("FAIL rst_mid: got valid %b word %h ready %b want 0 0 1", io_out_valid, dut_word, io_in_ready); end
    @(posedge clock);
    #1 io_in_valid = 1'b1; io_op = 1'b0; io_fpin1 = 16'h3C00; io_fpin2 = 16'h4000;
    want = model(1'b0, 16'h3C00, 16'h4000);
    @(posedge clock);
    #1 io_in_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale: out_valid got %b want 0", io_out_valid); end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (io_out_valid !== 1'b1 || dut_word !== want)
      begin errors++; $display("FAIL rst_first: got valid %b word %h want 1 %h", io_out_valid, dut_word, want); end
    @(posedge clock);
  endtask

  task automatic test_random();
    logic [OUT_W-1:0] held, want;
    bit stalled;
    int sent, got;
    sent = 0; got = 0; stalled = 0; held = '0;
    exp_q.delete();
    for (int cyc = 0; cyc < 3000 && got < 300; cyc++) begin
      @(posedge clock);
      #1 io_out_ready = ($urandom_range(0, 3) != 0);
      if (!(io_in_valid && !io_in_ready) || sent >= 300) begin
        io_in_valid = (sent < 300) && ($urandom_range(0, 3) != 0);
        io_op = 1'($urandom_range(0, 1));
        io_fpin1 = rand_operand();
        io_fpin2 = rand_operand();
      end
      @(negedge clock);
      if (stalled) begin
        checks++;
        if (dut_word !== held || io_out_valid !== 1'b1)
          begin errors++; $display("FAIL rnd_stable: got %h want %h", dut_word, held); end
      end
      stalled = io_out_valid && !io_out_ready;
      held = dut_word;
      if (io_out_valid && io_out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL rnd_extra: got %h want none", dut_word); end
        else begin
          want = exp_q.pop_front();
          if (dut_word !== want) begin errors++; $display("FAIL rnd_item%0d: got %h want %h", got, dut_word, want); end
        end
        got++;
      end
      if (io_in_valid && io_in_ready) begin
        exp_q.push_back(model(io_op, io_fpin1, io_fpin2));
        sent++;
      end
    end
    #1 io_in_valid = 1'b0;
    checks++;
    if (got != 300) begin errors++; $display("FAIL rnd_count: got %0d want 300", got); end
  endtask

  initial begin
    reset = 1'b1; io_in_valid = 1'b0; io_out_ready = 1'b1;
    io_op = 1'b0; io_fpin1 = '0; io_fpin2 = '0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
